// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter feeding a registered 4:1 word mux
// Picks a winner among four requesters, captures its word and holds it under valid/ready.
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] data_in,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic [1:0]         win_idx;
  logic               arb_event;

  // Scan from the farthest offset back to ptr so the nearest requester overwrites.
  always_comb begin
    win_idx = ptr_q;
    for (int j = 3; j >= 0; j--) begin
      if (req[ptr_q + 2'(j)]) begin
        win_idx = ptr_q + 2'(j);
      end
    end
  end

  assign arb_event = (|req) && ((state_q == IDLE) || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = 4'b0000;
    data_d  = data_q;
    if (arb_event) begin
      state_d = HOLD;
      ptr_d   = win_idx + 2'd1;
      sel_d   = win_idx;
      gnt_d   = 4'b0001 << win_idx;
      data_d  = data_in[win_idx*WIDTH +: WIDTH];
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    out_valid = (state_q == HOLD);
    busy      = (state_q == HOLD);
    gnt       = gnt_q;
    sel       = sel_q;
    out_data  = data_q;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 data multiplexer between four requesters and registers the selected word toward a single downstream consumer. It picks a winner, drives the mux select, captures the winner's word, and holds it under a valid/ready handshake. It is the sequencing front-end for the 4:1 select path and lets any four sources share one output channel fairly.

## Interface
- WIDTH, 8: data word width per requester.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  4  request per requester; req[i] high means data_in slice i is valid.
- data_in  in  4*WIDTH  requester words; slice i is data_in[i*WIDTH +: WIDTH].
- gnt  out  4  one-hot, registered, one-cycle pulse marking the requester whose word was captured.
- sel  out  2  index of the requester currently owning the output (mux select).
- out_valid  out  1  out_data holds an untaken word.
- out_data  out  WIDTH  registered word of the selected requester.
- out_ready  in  1  downstream accepts out_data when out_valid && out_ready.
- busy  out  1  equals out_valid.

## Operation
- Two states: IDLE (out_valid=0) and HOLD (out_valid=1).
- Arbitration event: (IDLE and |req) or (HOLD and out_ready and |req).
- On an arbitration event:
  - The winner k is the first i with req[i]=1 in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - out_data <= data_in slice k, sel <= k, gnt <= one-hot(k), out_valid <= 1.
  - ptr <= (k+1) mod 4, so 3 wraps to 0.
- HOLD with out_ready=1 and req=0: out_valid <= 0, return to IDLE. sel and out_data keep their last values.
- HOLD with out_ready=0: out_data, sel and out_valid are held stable. Requests wait and no gnt pulses.
- IDLE with req=0: no change.
- gnt is 0 in every cycle that is not the cycle immediately after an arbitration event.
- Requester contract:
  - Hold data_in stable while req is high.
  - The gnt cycle means the word was consumed.
  - If req is still high during its gnt cycle, the requester is presenting a new word and competes again under the rotated pointer.
- A lone persistent requester wins every arbitration event. Fairness applies only among simultaneous requesters.
- Width rules:
  - ptr and sel are 2 bits and wrap modulo 4.
  - out_data is exactly WIDTH bits with no extension or truncation.

## Timing
- Reset (rst=1 at an edge): out_valid=0, busy=0, gnt=4'b0000, sel=2'b00, out_data=0, ptr=0, state IDLE. rst overrides any handshake in progress in the same cycle, and the held word is dropped.
- Latency from req rising (sampled at edge N) to out_valid/gnt high is 1 cycle (visible after edge N).
- Back-to-back transfers: with out_ready held high and requests pending, one word is delivered per cycle.
- Simultaneous accept and request: the accept and the new capture happen on the same edge, with no bubble.
- Outputs are all registered. out_valid never drops without an accept or a reset.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=4'b1111 -> out_valid=0, gnt=0, sel=0, out_data=0. After release, the first grant goes to requester 0.
- Single requester: req=4'b0100, data slice 2=8'hA5, out_ready=1 -> next cycle out_valid=1, sel=2, out_data=8'hA5, gnt=4'b0100 for exactly one cycle.
- Fair rotation: req=4'b1111 held, out_ready=1, slice i=8'h10+i -> out_data sequence 10,11,12,13,10 on consecutive cycles, and gnt walks 0001,0010,0100,1000,0001.
- Backpressure: with a word valid, out_ready=0 for 3 cycles and req=4'b0011 -> out_data, sel and out_valid are stable and gnt=0. When out_ready rises, the next winner is captured on that same edge.
- Pointer wrap: grant requester 3, then req=4'b1001 -> requester 0 wins (ptr wrapped to 0). Then req=4'b1001 -> requester 3 wins.
- Reset mid-transfer: out_valid=1, out_ready=0, assert rst for 1 cycle -> out_valid=0, ptr=0. After release with req=4'b1010 -> requester 1 wins.
